// File: rtl/lut_func_eval.sv
// Run-time programmable IN_W-input / OUT_W-output Boolean function unit.
// A 2^IN_W-entry truth table is streamed in over the cfg port, then looked up per input word.
module lut_func_eval #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic [OUT_W-1:0] cfg_data,
   output logic             cfg_ready,
   output logic             cfg_done,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  X,
   output logic             in_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] Y,
   input  logic             out_ready
);

   localparam int DEPTH = 1 << IN_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;
   localparam logic [1:0] ST_RUN   = 2'd3;

   localparam logic [IN_W:0]    CNT_ZERO = {(IN_W+1){1'b0}};
   localparam logic [IN_W:0]    CNT_ONE  = {{IN_W{1'b0}}, 1'b1};
   localparam logic [IN_W:0]    CNT_LAST = {1'b0, {IN_W{1'b1}}};
   localparam logic [OUT_W-1:0] Y_ZERO   = {OUT_W{1'b0}};

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [IN_W:0]    cnt_r;
   logic [IN_W:0]    cnt_nxt_s;
   logic [OUT_W-1:0] table_r [DEPTH];
   logic             out_valid_r;
   logic [OUT_W-1:0] y_r;
   logic             cfg_ready_r;
   logic             cfg_done_r;
   logic             accept_in_s;
   logic             pop_s;
   logic             wr_s;

   // cfg_start always wins: it blocks both a table write and an input accept in its cycle
   assign pop_s       = out_valid_r & out_ready;
   assign in_ready    = cfg_done_r & (~out_valid_r | out_ready);
   assign accept_in_s = in_ready & in_valid & ~cfg_start;
   assign wr_s        = (state_r == ST_LOAD) & cfg_valid & ~cfg_start;

   assign cfg_ready = cfg_ready_r;
   assign cfg_done  = cfg_done_r;
   assign out_valid = out_valid_r;
   assign Y         = y_r;

   // Next-state and load-counter decode
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (cfg_start) begin
               state_nxt_s = ST_LOAD;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (cfg_start) begin
               cnt_nxt_s = CNT_ZERO;
            end else if (cfg_valid) begin
               cnt_nxt_s = cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_LOAD;
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_RUN: begin
            // a result that is popped in the restart cycle needs no drain phase
            if (cfg_start) begin
               cnt_nxt_s = CNT_ZERO;
               if (out_valid_r && !out_ready) begin
                  state_nxt_s = ST_DRAIN;
               end else begin
                  state_nxt_s = ST_LOAD;
               end
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (pop_s) begin
               state_nxt_s = ST_LOAD;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // State, counter and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         cfg_ready_r <= 1'b0;
         cfg_done_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         cfg_ready_r <= (state_nxt_s == ST_LOAD);
         cfg_done_r  <= (state_nxt_s == ST_RUN);
      end
   end

   // Truth table storage; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_s) begin
         table_r[cnt_r[IN_W-1:0]] <= cfg_data;
      end
   end

   // Single output register with pass-through backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         y_r         <= Y_ZERO;
      end else if (accept_in_s) begin
         out_valid_r <= 1'b1;
         y_r         <= table_r[X];
      end else if (pop_s) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

endmodule

// File: tb/tb_lut_func_eval.sv
// Self-checking bench for lut_func_eval: behavioural table model checked every cycle,
// directed scenarios with literal expectations, randomized traffic and a 6/3 parameter sweep.
module tb_lut_func_eval;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       cfg_start, cfg_valid, in_valid, out_ready;
   logic [3:0] cfg_data, x;
   logic       cfg_ready, cfg_done, in_ready, out_valid;
   logic [3:0] y;

   logic       b_cfg_start, b_cfg_valid, b_in_valid, b_out_ready;
   logic [2:0] b_cfg_data;
   logic [5:0] b_x;
   logic       b_cfg_ready, b_cfg_done, b_in_ready, b_out_valid;
   logic [2:0] b_y;

   lut_func_eval #(.IN_W(4), .OUT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
      .in_valid(in_valid), .X(x), .in_ready(in_ready), .out_valid(out_valid),
      .Y(y), .out_ready(out_ready));

   lut_func_eval #(.IN_W(6), .OUT_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .cfg_start(b_cfg_start), .cfg_valid(b_cfg_valid),
      .cfg_data(b_cfg_data), .cfg_ready(b_cfg_ready), .cfg_done(b_cfg_done),
      .in_valid(b_in_valid), .X(b_x), .in_ready(b_in_ready), .out_valid(b_out_valid),
      .Y(b_y), .out_ready(b_out_ready));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what the block is doing, the table it holds, and its pending result
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_WAIT = 3;
   int  m_mode = M_IDLE;
   int  m_next = 0;
   int  m_tab [16];
   bit  m_ov   = 1'b0;
   int  m_y    = 0;

   function automatic void model_step();
      bit push;
      bit pop;
      if (!rst_n) begin
         m_mode = M_IDLE; m_next = 0; m_ov = 1'b0; m_y = 0;
         return;
      end
      pop  = m_ov && out_ready;
      push = (m_mode == M_RUN) && in_valid && (!m_ov || out_ready) && !cfg_start;
      if (m_mode == M_LOAD) begin
         if (cfg_start) m_next = 0;
         else if (cfg_valid) begin
            m_tab[m_next] = int'(cfg_data);
            m_next++;
            if (m_next == 16) m_mode = M_RUN;
         end
      end else if (m_mode == M_IDLE) begin
         if (cfg_start) begin m_mode = M_LOAD; m_next = 0; end
      end else if (m_mode == M_WAIT) begin
         if (pop) begin m_mode = M_LOAD; m_next = 0; m_ov = 1'b0; end
         return;
      end else begin
         if (cfg_start) begin
            m_mode = (m_ov && !pop) ? M_WAIT : M_LOAD;
            m_next = 0;
         end
         if (push) begin m_ov = 1'b1; m_y = m_tab[x]; end
         else if (pop) m_ov = 1'b0;
      end
   endfunction

   // Every-cycle compare of the 4/4 instance against the model
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("cfg_ready", cfg_ready, 32'(m_mode == M_LOAD));
         chk("cfg_done", cfg_done, 32'(m_mode == M_RUN));
         chk("in_ready", in_ready, 32'((m_mode == M_RUN) && (!m_ov || out_ready)));
         chk("out_valid", out_valid, 32'(m_ov));
         if (m_ov) chk("y", y, 32'(m_y));
      end
   end

   logic [3:0] tbl [16];

   task automatic idle_cycle();
      @(negedge clk);
      cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic load(input bit gap, input string tag);
      @(negedge clk);
      cfg_start = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (gap && i[0]) begin
            @(negedge clk);
            cfg_start = 1'b0; cfg_valid = 1'b0;
         end
         @(negedge clk);
         cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = tbl[i];
         if (i == 15) chk({tag, "_done_before_last"}, cfg_done, 32'd0);
      end
      @(posedge clk); #1;
      chk({tag, "_done_after_last"}, cfg_done, 32'd1);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic push(input logic [3:0] xv, input logic ordy);
      @(negedge clk);
      in_valid = 1'b1; x = xv; out_ready = ordy;
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 4'd0;
      in_valid = 1'b0; x = 4'd0; out_ready = 1'b0;
      b_cfg_start = 1'b0; b_cfg_valid = 1'b0; b_cfg_data = 3'd0;
      b_in_valid = 1'b0; b_x = 6'd0; b_out_ready = 1'b0;

      @(posedge clk); #1;
      chk("rst_cfg_ready", cfg_ready, 32'd0);
      chk("rst_cfg_done", cfg_done, 32'd0);
      chk("rst_in_ready", in_ready, 32'd0);
      chk("rst_out_valid", out_valid, 32'd0);
      chk("rst_y", y, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b1; x = 4'd3;
      repeat (5) begin
         @(posedge clk); #1;
         chk("idle_in_ready", in_ready, 32'd0);
         chk("idle_out_valid", out_valid, 32'd0);
      end

      // Full load of (3*i) mod 16, then lookups at latency 1
      for (int i = 0; i < 16; i++) tbl[i] = 4'((3 * i) & 15);
      load(1'b0, "full");
      push(4'd5, 1'b1);
      @(posedge clk); #1;
      chk("x5_y", y, 32'hF);
      chk("x5_valid", out_valid, 32'd1);
      push(4'd15, 1'b1);
      @(posedge clk); #1;
      chk("x15_y", y, 32'hD);

      // Backpressure hold, then pop+push with no bubble
      idle_cycle();
      push(4'd2, 1'b0);
      @(posedge clk); #1;
      chk("bp_y", y, 32'h6);
      @(negedge clk);
      x = 4'd7;
      repeat (4) begin
         @(posedge clk); #1;
         chk("bp_hold_in_ready", in_ready, 32'd0);
         chk("bp_hold_y", y, 32'h6);
         chk("bp_hold_valid", out_valid, 32'd1);
      end
      @(negedge clk);
      out_ready = 1'b1; #1;
      chk("bp_release_in_ready", in_ready, 32'd1);
      @(posedge clk); #1;
      chk("nobubble_y", y, 32'h5);
      chk("nobubble_valid", out_valid, 32'd1);

      // Gapped load of (5*i+1) mod 16
      idle_cycle(); idle_cycle();
      for (int i = 0; i < 16; i++) tbl[i] = 4'((5 * i + 1) & 15);
      load(1'b1, "gap");
      push(4'd9, 1'b1);
      @(posedge clk); #1;
      chk("gap_x9_y", y, 32'hE);

      // Restarted load: start+valid after entry 8 discards that entry
      idle_cycle(); idle_cycle();
      @(negedge clk);
      cfg_start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 4'h3;
      end
      @(negedge clk);
      cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 4'h5;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 4'hA;
         if (i == 15) chk("restart_done_before_last", cfg_done, 32'd0);
      end
      @(posedge clk); #1;
      chk("restart_done_after_last", cfg_done, 32'd1);
      @(negedge clk);
      cfg_valid = 1'b0;
      push(4'd9, 1'b1);
      @(posedge clk); #1;
      chk("restart_x9_y", y, 32'hA);

      // Reload while a result is stalled
      push(4'd1, 1'b0);
      @(posedge clk); #1;
      chk("busy_valid", out_valid, 32'd1);
      @(negedge clk);
      in_valid = 1'b0; cfg_start = 1'b1;
      @(posedge clk); #1;
      chk("busy_done_fall", cfg_done, 32'd0);
      chk("busy_y_held", y, 32'hA);
      chk("busy_cfg_ready", cfg_ready, 32'd0);
      @(negedge clk);
      cfg_start = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("drain_pop", out_valid, 32'd0);
      chk("drain_cfg_ready", cfg_ready, 32'd1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         cfg_valid = 1'b1; cfg_data = 4'((3 * i) & 15);
      end
      @(negedge clk);
      cfg_valid = 1'b0;

      // Asynchronous reset mid-cycle with a pending result
      push(4'd4, 1'b0);
      @(posedge clk); #1;
      chk("pre_rst_y", y, 32'hC);
      @(negedge clk);
      rst_n = 1'b0; #1;
      chk("async_rst_valid", out_valid, 32'd0);
      chk("async_rst_y", y, 32'd0);
      chk("async_rst_done", cfg_done, 32'd0);
      chk("async_rst_in_ready", in_ready, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;

      // Randomized traffic including rare restarts and resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n     = ($urandom_range(0, 399) != 0);
         cfg_start = ($urandom_range(0, 99) == 0);
         cfg_valid = ($urandom_range(0, 3) != 0);
         cfg_data  = 4'($urandom);
         in_valid  = ($urandom_range(0, 1) == 1);
         x         = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0;

      // IN_W=6 / OUT_W=3 instance: table[i] = i mod 8
      @(negedge clk);
      b_cfg_start = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         b_cfg_start = 1'b0; b_cfg_valid = 1'b1; b_cfg_data = 3'(i % 8);
         if (i == 63) chk("b_done_before_last", b_cfg_done, 32'd0);
      end
      @(posedge clk); #1;
      chk("b_done_after_last", b_cfg_done, 32'd1);
      @(negedge clk);
      b_cfg_valid = 1'b0; b_in_valid = 1'b1; b_x = 6'd45; b_out_ready = 1'b1;
      @(posedge clk); #1;
      chk("b_x45_y", b_y, 32'd5);
      chk("b_x45_valid", b_out_valid, 32'd1);
      @(negedge clk);
      b_in_valid = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lut_func_eval.md
Name: lut_func_eval

Overview:
- Run-time programmable N-input / M-output Boolean function unit: a truth table of 2^IN_W entries × OUT_W bits is streamed in over a config port, then evaluated per input word.
- Successor to our fixed, hand-minimised combinational function blocks: one netlist implements any function of IN_W variables, reloadable without resynthesis.
- Sits between a stimulus source (switches/UART decoder) and display/output logic on the lab FPGA board.

Parameters:
- IN_W, 4, number of function inputs; table depth DEPTH = 2^IN_W.
- OUT_W, 4, number of function outputs (bits per table entry).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_start  input  1  pulse: begin (or restart) table load.
- cfg_valid  input  1  cfg_data holds the next table entry.
- cfg_data  input  OUT_W  table entry; entries arrive in address order 0..DEPTH-1.
- cfg_ready  output  1  entry accepted when cfg_valid && cfg_ready.
- cfg_done  output  1  table fully loaded; block is in RUN.
- in_valid  input  1  X valid.
- X  input  IN_W  function argument.
- in_ready  output  1  X accepted when in_valid && in_ready.
- out_valid  output  1  Y valid.
- Y  output  OUT_W  function value table[X].
- out_ready  input  1  downstream accepts Y.

Behaviour:
- States: IDLE (no valid table), DRAIN (load requested, output pending), LOAD, RUN.
- Reset (async, rst_n=0):
  - state=IDLE, load counter=0.
  - All outputs 0: cfg_ready, cfg_done, in_ready, out_valid, Y.
  - Table contents are not reset (undefined until loaded).
- IDLE:
  - cfg_start → LOAD, counter=0.
  - cfg_valid and in_valid are ignored.
- LOAD:
  - cfg_ready=1.
  - Each accepted entry is written to table[counter]; counter increments.
  - Acceptance of entry DEPTH-1 → RUN next cycle; cfg_done=1 from that cycle.
  - cfg_start in LOAD restarts at counter=0; a cfg_valid in the same cycle is discarded (start wins).
  - in_ready=0 throughout.
- RUN:
  - cfg_ready=0; cfg_done=1.
  - in_ready = !out_valid || out_ready (single output register with pass-through backpressure).
  - Accepted X at edge t → out_valid=1 and Y=table[X] after edge t (latency 1 cycle).
  - Y and out_valid are held stable until out_valid && out_ready.
  - Simultaneous pop and push in the same cycle: the register reloads with the new value, out_valid stays 1 (full throughput).
  - cfg_start in RUN:
    - cfg_done drops next cycle; in_ready=0 from then on.
    - If out_valid=0 → LOAD.
    - Else → DRAIN, which waits for out_valid && out_ready, then → LOAD.
    - An X presented in the same cycle as cfg_start is not accepted.
- cfg_done stays 0 in IDLE, DRAIN and LOAD.
- Counter is IN_W+1 bits wide; no wrap within one load. Extra cfg_valid after the last entry is ignored (cfg_ready=0 in RUN).
- Reset mid-load → IDLE; the partial table is unusable until a full reload.
- No combinational path from cfg_* to Y. in_ready may depend combinationally on out_ready only.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle → all outputs 0 immediately; after release, in_valid=1, X=3 held for 5 cycles → in_ready=0, out_valid=0.
- Full load, IN_W=4/OUT_W=4:
  - Stream entries table[i]=(3*i)&0xF, one per cycle → cfg_done=1 exactly 1 cycle after the 16th accept.
  - Then X=5 → Y=0xF; X=15 → Y=0xD; each at latency 1.
- Backpressure:
  - out_ready=0 with X=2 accepted → out_valid=1, Y=0x6 held, in_ready=0 for 4 cycles.
  - out_ready=1 with X=7 presented in the same cycle → next Y=0x5, no bubble.
- Gapped and restarted load:
  - cfg_valid toggling 1/0 during load → still exactly 16 writes.
  - cfg_start+cfg_valid after entry 8 → counter restarts; new entries all 0xA; X=9 → Y=0xA.
- Reload while busy:
  - In RUN with out_valid=1, out_ready=0, pulse cfg_start → cfg_done falls, Y held.
  - Then out_ready=1 → pop; LOAD begins; cfg_ready=1 the following cycle.
- Parameter sweep: IN_W=6, OUT_W=3 load table[i]=i%8 → X=45 gives Y=5; cfg_done after exactly 64 accepts.
